thunderbird_stalk_cond: RTL and testbench

- Input conditioner directly upstream of the thunderbird tail-light sequencer; drives its left/right request inputs.
- Synchronises and debounces the raw turn-stalk and hazard switches and enforces mutual exclusion, so the sequencer only sees clean, single-direction requests.
- Hazard overrides turn requests.
- Optionally stretches a short stalk tap into a fixed lane-change request.

---
 rtl/thunderbird_stalk_cond.sv | 172 +++++++++++++++++
 tb/tb_thunderbird_stalk_cond.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thunderbird_stalk_cond.sv
// thunderbird_stalk_cond: conditions the raw turn-stalk and hazard switches
// for the thunderbird tail-light sequencer. Each input is synchronised and
// debounced. Turn requests are made mutually exclusive, and hazard takes
// priority over both turn directions.
// Optional feature: define THUNDERBIRD_LANE_CHANGE_EN to stretch a short
// stalk tap into a fixed-length lane-change request.
// Handshake note: there is no valid/ready traffic here. Every output is a
// registered level that is valid on every cycle once reset is released.
// state_dbg exposes the FSM state register so that checkers can bind to it.
module thunderbird_stalk_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int TAP_MAX    = 16,
    parameter int LC_CYCLES  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_raw,
    input  logic       right_raw,
    input  logic       hazard_raw,
    output logic       left,
    output logic       right,
    output logic       hazard_active,
    output logic       conflict,
    output logic [2:0] state_dbg
);

    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    // Parameter sanity check; nothing is generated when the values are legal.
    if (DEB_CYCLES < 1 || TAP_MAX < 1 || LC_CYCLES < 1) begin : g_param_check
        $error("thunderbird_stalk_cond: DEB_CYCLES, TAP_MAX and LC_CYCLES must be >= 1");
    end

`ifdef THUNDERBIRD_LANE_CHANGE_EN
    localparam int PW = $clog2(TAP_MAX + 1);
    localparam int LW = $clog2(LC_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEFT, ST_RIGHT, ST_HAZARD, ST_LC_LEFT, ST_LC_RIGHT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEFT, ST_RIGHT, ST_HAZARD
    } state_t;
`endif

    // Channel bit order: 0 = left, 1 = right, 2 = hazard.
    logic [2:0] raw_vec;
    logic [2:0] s1, s2, deb;
    logic [DW-1:0] deb_cnt [3];
    state_t state_q, state_d;
    logic left_d, right_d, haz_d;

    assign raw_vec   = {hazard_raw, right_raw, left_raw};
    assign state_dbg = state_q;

    // Two-flop synchroniser on each raw contact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_vec;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_deb
        // The debounced level follows s2 only after DEB_CYCLES consecutive mismatching edges.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                deb_cnt[g] <= '0;
                deb[g]     <= 1'b0;
            end else if (s2[g] == deb[g]) begin
                deb_cnt[g] <= '0;
            end else if (deb_cnt[g] == DW'(DEB_CYCLES - 1)) begin
                deb[g]     <= s2[g];
                deb_cnt[g] <= '0;
            end else begin
                deb_cnt[g] <= deb_cnt[g] + 1'b1;
            end
        end
    end

`ifdef THUNDERBIRD_LANE_CHANGE_EN
    logic [PW-1:0] press_cnt;
    logic [LW-1:0] lc_cnt;

    // The press length counts edges spent in LEFT/RIGHT. The entry edge counts as 1, and the count saturates at TAP_MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_cnt <= '0;
        end else if (state_d == ST_LEFT || state_d == ST_RIGHT) begin
            if (state_d != state_q)
                press_cnt <= PW'(1);
            else if (press_cnt < PW'(TAP_MAX))
                press_cnt <= press_cnt + 1'b1;
        end else begin
            press_cnt <= '0;
        end
    end

    // The lane-change hold timer counts edges spent in an LC state, starting at 1 on the entry edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lc_cnt <= '0;
        end else if (state_d == ST_LC_LEFT || state_d == ST_LC_RIGHT) begin
            if (state_d != state_q)
                lc_cnt <= LW'(1);
            else
                lc_cnt <= lc_cnt + 1'b1;
        end else begin
            lc_cnt <= '0;
        end
    end
`endif

    // Next-state logic: hazard first, then conflict, then single directions, and otherwise a release.
    always_comb begin
        state_d = ST_IDLE;
        left_d  = 1'b0;
        right_d = 1'b0;
        haz_d   = 1'b0;
        if (deb[2]) begin
            state_d = ST_HAZARD;
        end else if (deb[0] && deb[1]) begin
            state_d = ST_IDLE;
        end else if (deb[0]) begin
            state_d = ST_LEFT;
        end else if (deb[1]) begin
            state_d = ST_RIGHT;
        end else begin
`ifdef THUNDERBIRD_LANE_CHANGE_EN
            case (state_q)
                ST_LEFT:     state_d = (press_cnt < PW'(TAP_MAX)) ? ST_LC_LEFT : ST_IDLE;
                ST_RIGHT:    state_d = (press_cnt < PW'(TAP_MAX)) ? ST_LC_RIGHT : ST_IDLE;
                ST_LC_LEFT:  state_d = (lc_cnt < LW'(LC_CYCLES)) ? ST_LC_LEFT : ST_IDLE;
                ST_LC_RIGHT: state_d = (lc_cnt < LW'(LC_CYCLES)) ? ST_LC_RIGHT : ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
`else
            state_d = ST_IDLE;
`endif
        end
`ifdef THUNDERBIRD_LANE_CHANGE_EN
        left_d  = (state_d == ST_LEFT)  || (state_d == ST_LC_LEFT)  || (state_d == ST_HAZARD);
        right_d = (state_d == ST_RIGHT) || (state_d == ST_LC_RIGHT) || (state_d == ST_HAZARD);
`else
        left_d  = (state_d == ST_LEFT)  || (state_d == ST_HAZARD);
        right_d = (state_d == ST_RIGHT) || (state_d == ST_HAZARD);
`endif
        haz_d = (state_d == ST_HAZARD);
    end

    // State and output registers. The outputs are decoded from the next state, so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            left          <= 1'b0;
            right         <= 1'b0;
            hazard_active <= 1'b0;
            conflict      <= 1'b0;
        end else begin
            state_q       <= state_d;
            left          <= left_d;
            right         <= right_d;
            hazard_active <= haz_d;
            conflict      <= deb[0] & deb[1];
        end
    end

endmodule

// File: tb/tb_thunderbird_stalk_cond.sv
// Testbench for thunderbird_stalk_cond. A reference model computes the
// expected outputs from the history of raw samples.
module tb_thunderbird_stalk_cond;

    localparam int DEB = 4;
    localparam int TAP = 16;
    localparam int LC  = 12;
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic left_raw = 1'b0, right_raw = 1'b0, hazard_raw = 1'b0;
    logic left, right, hazard_active, conflict;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_fail = 0;
    int n_edge = 0;
    bit in_reset = 1'b1;

    // Reference model state.
    bit hist [0:2][0:HMAX-1];
    bit m_deb [3];
    logic exp_l = 1'b0, exp_r = 1'b0, exp_h = 1'b0, exp_c = 1'b0;
    int m_dir = 0;
    int m_press = 0;
    int m_hold = 0;

    thunderbird_stalk_cond #(.DEB_CYCLES(DEB), .TAP_MAX(TAP), .LC_CYCLES(LC)) dut (
        .clk(clk), .reset(reset),
        .left_raw(left_raw), .right_raw(right_raw), .hazard_raw(hazard_raw),
        .left(left), .right(right), .hazard_active(hazard_active),
        .conflict(conflict), .state_dbg(state_dbg)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, n_edge, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit hs(input int ch, input int k);
        return (k < 1) ? 1'b0 : hist[ch][k];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++) m_deb[c] = 1'b0;
        exp_l = 1'b0; exp_r = 1'b0; exp_h = 1'b0; exp_c = 1'b0;
        m_dir = 0; m_press = 0; m_hold = 0;
        n_edge = 0;
    endtask

    // On each edge, the outputs come from the debounced levels seen before the edge.
    // A level flips once the last DEB visible samples all disagree with it.
    task automatic model_edge();
        bit l, r, h, mism;
        l = m_deb[0]; r = m_deb[1]; h = m_deb[2];
        exp_c = l & r;
`ifdef THUNDERBIRD_LANE_CHANGE_EN
        if (h || (l && r)) begin
            m_dir = 0; m_hold = 0; m_press = 0;
        end else if (l || r) begin
            if (m_dir == (l ? 1 : 2) && m_hold == 0)
                m_press = (m_press < TAP) ? m_press + 1 : TAP;
            else
                m_press = 1;
            m_dir = l ? 1 : 2;
            m_hold = 0;
        end else if (m_dir != 0 && m_hold == 0 && m_press < TAP) begin
            m_hold = 1;
        end else if (m_hold > 0 && m_hold < LC) begin
            m_hold++;
        end else begin
            m_dir = 0; m_hold = 0; m_press = 0;
        end
        exp_h = h;
        exp_l = h | (m_dir == 1);
        exp_r = h | (m_dir == 2);
`else
        exp_h = h;
        exp_l = h | (l & ~r);
        exp_r = h | (r & ~l);
`endif
        for (int c = 0; c < 3; c++) begin
            mism = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (hs(c, n_edge - 2 - j) == m_deb[c]) mism = 1'b0;
            if (mism) m_deb[c] = ~m_deb[c];
        end
    endtask

    task automatic check_outputs();
        check_bit("left", left, exp_l);
        check_bit("right", right, exp_r);
        check_bit("hazard_active", hazard_active, exp_h);
        check_bit("conflict", conflict, exp_c);
        check_bit("both_only_in_hazard", left & right & ~hazard_active, 1'b0);
    endtask

    // One clock: record raw samples at the edge, advance the model, then check at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!in_reset && n_edge < HMAX - 1) begin
            n_edge++;
            hist[0][n_edge] = left_raw;
            hist[1][n_edge] = right_raw;
            hist[2][n_edge] = hazard_raw;
            model_edge();
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asserts reset between edges, checks that the outputs clear without waiting for an edge, then releases at a falling edge.
    task automatic apply_reset(input int ncyc);
        #2;
        reset = 1'b0;
        in_reset = 1'b1;
        model_clear();
        #1;
        check_bit("async_reset_left", left, 1'b0);
        check_bit("async_reset_right", right, 1'b0);
        check_bit("async_reset_hazard", hazard_active, 1'b0);
        check_bit("async_reset_conflict", conflict, 1'b0);
        @(negedge clk);
        ticks(ncyc);
        reset = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic wait_left(input logic target, output int edges);
        edges = 0;
        while (left !== target && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    int lat;
    int rem [3];
    bit saw_left;

    initial begin
        // Reset for 3 cycles with all inputs low, then a period of idle.
        @(negedge clk);
        apply_reset(3);
        ticks(10);

        // A clean left step and its release; each should take 7 edges to reach the output.
        left_raw = 1'b1;
        wait_left(1'b1, lat);
        check_int("left_rise_latency", lat, 3 + DEB);
        check_bit("left_step_right", right, 1'b0);
        ticks(40 - lat);
        left_raw = 1'b0;
        wait_left(1'b0, lat);
`ifdef THUNDERBIRD_LANE_CHANGE_EN
        check_int("long_press_release_latency", lat, 3 + DEB);
`else
        check_int("left_fall_latency", lat, 3 + DEB);
`endif
        ticks(10);

        // Bounce on alternate cycles, then steady low: left must never assert.
        saw_left = 1'b0;
        for (int i = 0; i < 10; i++) begin
            left_raw = (i % 2 == 0);
            tick();
            if (left === 1'b1) saw_left = 1'b1;
        end
        left_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (left === 1'b1) saw_left = 1'b1;
        end
        check_bit("bounce_never_left", saw_left, 1'b0);

        // Left and right together give a conflict; dropping left hands over to right.
        left_raw = 1'b1;
        ticks(15);
        right_raw = 1'b1;
        ticks(15);
        check_bit("conflict_set", conflict, 1'b1);
        check_bit("conflict_left_low", left, 1'b0);
        check_bit("conflict_right_low", right, 1'b0);
        left_raw = 1'b0;
        ticks(15);
        check_bit("after_conflict_right", right, 1'b1);
        check_bit("after_conflict_clear", conflict, 1'b0);

        // Hazard overrides right, and releasing hazard returns to right.
        hazard_raw = 1'b1;
        ticks(15);
        check_bit("hazard_left", left, 1'b1);
        check_bit("hazard_right", right, 1'b1);
        check_bit("hazard_flag", hazard_active, 1'b1);
        hazard_raw = 1'b0;
        ticks(15);
        check_bit("hazard_release_right", right, 1'b1);
        check_bit("hazard_release_left", left, 1'b0);
        check_bit("hazard_release_flag", hazard_active, 1'b0);
        right_raw = 1'b0;
        ticks(30);

        // Reset in the middle of LEFT; a stalk that is still held re-asserts after the full latency.
        left_raw = 1'b1;
        ticks(20);
        check_bit("pre_reset_left", left, 1'b1);
        apply_reset(2);
        wait_left(1'b1, lat);
        check_int("post_reset_latency", lat, 3 + DEB);
        left_raw = 1'b0;
        ticks(40);

`ifdef THUNDERBIRD_LANE_CHANGE_EN
        // An 8-cycle tap holds left for LC edges after the debounced release.
        left_raw = 1'b1;
        ticks(8);
        left_raw = 1'b0;
        wait_left(1'b0, lat);
        check_int("tap_hold_latency", lat, 3 + DEB + LC);
        ticks(10);
        // Tap again, then assert hazard during the hold: hazard wins.
        left_raw = 1'b1;
        ticks(8);
        left_raw = 1'b0;
        ticks(10);
        hazard_raw = 1'b1;
        ticks(8);
        check_bit("tap_hazard_wins", hazard_active, 1'b1);
        hazard_raw = 1'b0;
        ticks(20);
        // A 30-cycle press gets no hold after release.
        left_raw = 1'b1;
        ticks(30);
        left_raw = 1'b0;
        wait_left(1'b0, lat);
        check_int("long_press_no_hold", lat, 3 + DEB);
        ticks(10);
`endif

        // Random runs on each input: a mix of short glitches and long holds.
        for (int c = 0; c < 3; c++) rem[c] = 0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (rem[c] == 0) begin
                    logic v;
                    v = (c == 2) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
                    case (c)
                        0: left_raw = v;
                        1: right_raw = v;
                        default: hazard_raw = v;
                    endcase
                end
                rem[c]--;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
